// File: rtl/index_mask_decoder_if.sv
// Index-to-mask stream bundle: indexed input beats and framed mask output.
interface index_mask_decoder_if #(
  parameter int OUTPUT_WIDTH = 8
);
  localparam int IDX_W = $clog2(OUTPUT_WIDTH);

  logic                    in_valid;
  logic                    in_ready;
  logic [IDX_W-1:0]        in_index;
  logic                    in_mode;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUTPUT_WIDTH-1:0] out_mask;
  logic                    out_error;

  modport master (
    output in_valid,
    output in_index,
    output in_mode,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_mask,
    input  out_error
  );

  modport slave (
    input  in_valid,
    input  in_index,
    input  in_mode,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_mask,
    output out_error
  );
endinterface

// File: rtl/index_mask_decoder.sv
// Decodes a stream of bit indices into one-hot or span masks and
// OR-accumulates them into one mask per frame.
module index_mask_decoder #(
  parameter int OUTPUT_WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  index_mask_decoder_if.slave bus
);
  typedef enum logic {
    ACCUM,
    HOLD
  } state_e;

  state_e state_q, state_d;

  logic [OUTPUT_WIDTH-1:0] acc_q, acc_d;
  logic                    err_q, err_d;
  logic [OUTPUT_WIDTH-1:0] mask_q, mask_d;
  logic                    oerr_q, oerr_d;

  logic [OUTPUT_WIDTH-1:0] dec;
  logic                    oob;
  int unsigned             idx_u;
  logic                    fire;
  logic                    drain;

  assign idx_u = 32'(bus.in_index);

  // Out-of-range span indices naturally give all ones via the compare.
  always_comb begin
    dec = '0;
    for (int unsigned i = 0; i < OUTPUT_WIDTH; i++) begin
      if (bus.in_mode) begin
        dec[i] = (i < idx_u);
      end else begin
        dec[i] = (i == idx_u);
      end
    end
  end

  assign oob = !bus.in_mode &&
               (idx_u >= 32'(OUTPUT_WIDTH));

  assign bus.in_ready  = (state_q == ACCUM) ||
                         bus.out_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_mask  = mask_q;
  assign bus.out_error = oerr_q;

  assign fire  = bus.in_valid && bus.in_ready;
  assign drain = (state_q == HOLD) &&
                 bus.out_ready && !fire;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    err_d   = err_q;
    mask_d  = mask_q;
    oerr_d  = oerr_q;
    unique case (1'b1)
      fire && bus.in_last: begin
        mask_d  = acc_q | dec;
        oerr_d  = err_q | oob;
        acc_d   = '0;
        err_d   = 1'b0;
        state_d = HOLD;
      end
      fire && !bus.in_last: begin
        acc_d   = acc_q | dec;
        err_d   = err_q | oob;
        state_d = ACCUM;
      end
      drain: begin
        state_d = ACCUM;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      err_q   <= 1'b0;
      mask_q  <= '0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      oerr_q  <= oerr_d;
    end
  end
endmodule
